// File: rtl/spgd_adc_pkg.sv
// Shared types and helpers for the SPGD ADC acquisition front end.
package spgd_adc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StAccum,
        StScale,
        StDone
    } adc_state_e;

    // Left shift that places raw full scale at +/-1.0 in the fixed-point result.
    function automatic int frac_shift(input int fp_width, input int int_width,
                                      input int raw_width);
        return fp_width - int_width - (raw_width - 1);
    endfunction

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int unsigned width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/spgd_adc_accum.sv
// Sample accumulator: sums sign-extended samples until 2^LOG2_AVG have been taken.
module spgd_adc_accum #(
    parameter int unsigned RAW_WIDTH = 14,
    parameter int unsigned LOG2_AVG  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          enable,
    input  logic [RAW_WIDTH-1:0]          sample,
    output logic [RAW_WIDTH+LOG2_AVG-1:0] acc,
    output logic                          reached
);

    logic [LOG2_AVG:0] count;

    // Count reaches exactly 2^LOG2_AVG, so its MSB alone flags completion.
    assign reached = count[LOG2_AVG];

    // Accumulate one sample per enabled cycle; further samples are ignored once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (enable && !reached) begin
            acc   <= acc + {{LOG2_AVG{sample[RAW_WIDTH-1]}}, sample};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spgd_adc_acquire.sv
// SPGD ADC acquisition: settle, average 2^LOG2_AVG samples, scale to fixed point.
// Optional build macro ADC_OFFSET_EN adds a per-sample saturated offset subtraction.
module spgd_adc_acquire
    import spgd_adc_pkg::*;
#(
    parameter int unsigned FP_WIDTH  = 32,
    parameter int unsigned INT_WIDTH = 16,
    parameter int unsigned RAW_WIDTH = 14,
    parameter int unsigned LOG2_AVG  = 4,
    parameter int unsigned SETTLE_W  = 16
) (
    input  logic                 ADC_CLK,
    input  logic                 REG_RST_N,
    input  logic                 ADC_EN,
    input  logic [RAW_WIDTH-1:0] ADC_RAW,
    input  logic                 ADC_RAW_VALID,
    input  logic [SETTLE_W-1:0]  SETTLE_CYC,
`ifdef ADC_OFFSET_EN
    input  logic [RAW_WIDTH-1:0] ADC_OFFSET,
`endif
    output logic [FP_WIDTH-1:0]  ADC_OUT,
    output logic                 ADC_DONE,
    output logic                 BUSY
);

    localparam int ACC_W      = int'(RAW_WIDTH + LOG2_AVG);
    localparam int FRAC_SHIFT = frac_shift(int'(FP_WIDTH), int'(INT_WIDTH), int'(RAW_WIDTH));

    if (FRAC_SHIFT < 0) begin : gen_width_check
        $error("spgd_adc_acquire: FP_WIDTH-INT_WIDTH must be >= RAW_WIDTH-1");
    end

    adc_state_e                state;
    logic [SETTLE_W-1:0]       settle_cnt;
    logic [RAW_WIDTH-1:0]      sample;
    logic [ACC_W-1:0]          acc;
    logic                      reached;
    logic                      acc_clear;
    logic                      acc_enable;
    logic signed [ACC_W-1:0]   avg_full;
    logic signed [FP_WIDTH-1:0] avg_ext;
    logic [FP_WIDTH-1:0]       scaled;

`ifdef ADC_OFFSET_EN
    logic signed [RAW_WIDTH:0] diff;
    logic signed [31:0]        diff_sat;

    // One extra bit keeps raw minus offset exact before clamping back to raw range.
    assign diff     = $signed({ADC_RAW[RAW_WIDTH-1], ADC_RAW})
                    - $signed({ADC_OFFSET[RAW_WIDTH-1], ADC_OFFSET});
    assign diff_sat = sat_signed(32'(diff), RAW_WIDTH);
    assign sample   = diff_sat[RAW_WIDTH-1:0];
`else
    assign sample = ADC_RAW;
`endif

    assign acc_clear  = (state == StIdle) && ADC_EN;
    assign acc_enable = (state == StAccum) && ADC_EN && ADC_RAW_VALID;

    // Arithmetic shift gives a floored mean; the cast sign-extends before scaling.
    assign avg_full = $signed(acc) >>> LOG2_AVG;
    assign avg_ext  = FP_WIDTH'(avg_full);
    assign scaled   = avg_ext <<< FRAC_SHIFT;

    spgd_adc_accum #(
        .RAW_WIDTH (RAW_WIDTH),
        .LOG2_AVG  (LOG2_AVG)
    ) u_accum (
        .clk     (ADC_CLK),
        .rst_n   (REG_RST_N),
        .clear   (acc_clear),
        .enable  (acc_enable),
        .sample  (sample),
        .acc     (acc),
        .reached (reached)
    );

    // Measurement FSM with settle counter and registered outputs.
    always_ff @(posedge ADC_CLK or negedge REG_RST_N) begin
        if (!REG_RST_N) begin
            state      <= StIdle;
            settle_cnt <= '0;
            ADC_OUT    <= '0;
            ADC_DONE   <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (ADC_EN) begin
                        state      <= StSettle;
                        settle_cnt <= SETTLE_CYC;
                        BUSY       <= 1'b1;
                    end
                end
                StSettle: begin
                    if (!ADC_EN) begin
                        state <= StIdle;
                        BUSY  <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= StAccum;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StAccum: begin
                    if (!ADC_EN) begin
                        state <= StIdle;
                        BUSY  <= 1'b0;
                    end else if (reached) begin
                        state <= StScale;
                    end
                end
                StScale: begin
                    BUSY <= 1'b0;
                    if (!ADC_EN) begin
                        state <= StIdle;
                    end else begin
                        state    <= StDone;
                        ADC_OUT  <= scaled;
                        ADC_DONE <= 1'b1;
                    end
                end
                StDone: begin
                    // Four-phase: requester must drop ADC_EN before another request.
                    if (!ADC_EN) begin
                        state    <= StIdle;
                        ADC_DONE <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    ADC_DONE <= 1'b0;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spgd_adc_acquire.sv
// Directed self-checking bench for spgd_adc_acquire.
module tb_spgd_adc_acquire;

    logic        clk;
    logic        rst_n;
    logic        adc_en;
    logic [13:0] adc_raw;
    logic        adc_raw_valid;
    logic [15:0] settle_cyc;
`ifdef ADC_OFFSET_EN
    logic [13:0] adc_offset;
`endif
    logic [31:0] adc_out;
    logic        adc_done;
    logic        busy;

    int total;
    int bad;
    int de;
    int viol;

    spgd_adc_acquire dut (
        .ADC_CLK       (clk),
        .REG_RST_N     (rst_n),
        .ADC_EN        (adc_en),
        .ADC_RAW       (adc_raw),
        .ADC_RAW_VALID (adc_raw_valid),
        .SETTLE_CYC    (settle_cyc),
`ifdef ADC_OFFSET_EN
        .ADC_OFFSET    (adc_offset),
`endif
        .ADC_OUT       (adc_out),
        .ADC_DONE      (adc_done),
        .BUSY          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs seen at edge e. mode 0: 4096 always valid; 1: -8192/8191 valid on even
    // edges only; 2: 8150 always valid.
    task automatic drive_for_edge(input int e, input int mode);
        case (mode)
            0: begin adc_raw_valid = 1'b1; adc_raw = 14'h1000; end
            1: begin
                adc_raw_valid = (e % 2 == 0);
                adc_raw = ((e / 2) % 2 == 0) ? 14'h2000 : 14'h1FFF;
            end
            default: begin adc_raw_valid = 1'b1; adc_raw = 14'h1FD6; end
        endcase
    endtask

    // Request at edge 0; returns the edge where ADC_DONE is first seen high, or -1.
    task automatic measure(input logic [15:0] settle, input int mode, input int drop_edge,
                           input int max_edges, output int done_edge);
        adc_en     = 1'b1;
        settle_cyc = settle;
        drive_for_edge(0, mode);
        tick();
        check_eq("busy_after_req", 32'(busy), 32'd1);
        settle_cyc = 16'd200;  // must not affect the running measurement
        done_edge  = -1;
        for (int e = 1; e <= max_edges; e++) begin
            if (e == drop_edge) adc_en = 1'b0;
            drive_for_edge(e, mode);
            tick();
            if (adc_done && done_edge < 0) begin
                done_edge = e;
                break;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        adc_en = 1'b0;
        adc_raw = '0;
        adc_raw_valid = 1'b0;
        settle_cyc = '0;
`ifdef ADC_OFFSET_EN
        adc_offset = '0;
`endif
        #2;
        check_eq("rst_out", adc_out, 32'h0);
        check_eq("rst_done", 32'(adc_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Continuous samples, no settle, ADC_EN held high well past DONE.
        measure(16'd0, 0, -1, 60, de);
        check_eq("t1_done_edge", de, 32'd19);
        check_eq("t1_out", adc_out, 32'h0000_8000);
        check_eq("t1_busy_done", 32'(busy), 32'd0);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0 || adc_done !== 1'b1 || adc_out !== 32'h0000_8000) viol++;
        end
        check_eq("hold_single_meas", viol, 32'd0);
        adc_en = 1'b0;
        tick();
        check_eq("t1_done_fall", 32'(adc_done), 32'd0);
        tick();
        check_eq("t1_idle_busy", 32'(busy), 32'd0);

        // Abort during SETTLE.
        measure(16'd10, 0, 4, 30, de);
        check_eq("abort_settle_done", de, 32'hFFFF_FFFF);
        check_eq("abort_settle_out", adc_out, 32'h0000_8000);
        check_eq("abort_settle_busy", 32'(busy), 32'd0);

        // Abort during ACCUM.
        measure(16'd2, 0, 10, 30, de);
        check_eq("abort_accum_done", de, 32'hFFFF_FFFF);
        check_eq("abort_accum_out", adc_out, 32'h0000_8000);
        check_eq("abort_accum_busy", 32'(busy), 32'd0);

        // Alternating full-scale samples with a gap before every valid sample.
        measure(16'd5, 1, -1, 80, de);
        check_eq("t2_done_edge", de, 32'd40);
        check_eq("t2_out", adc_out, 32'hFFFF_FFF8);
        adc_en = 1'b0;
        tick();
        check_eq("t2_done_fall", 32'(adc_done), 32'd0);
        tick();

        // Asynchronous reset in the middle of ACCUM.
        adc_en = 1'b1;
        settle_cyc = 16'd0;
        drive_for_edge(0, 0);
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out", adc_out, 32'h0);
        check_eq("mid_rst_done", 32'(adc_done), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        adc_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        measure(16'd3, 0, -1, 60, de);
        check_eq("post_rst_done_edge", de, 32'd22);
        check_eq("post_rst_out", adc_out, 32'h0000_8000);
        adc_en = 1'b0;
        tick();
        tick();

`ifdef ADC_OFFSET_EN
        // Offset -100 pushes 8150 past full scale; each sample clamps to 8191.
        adc_offset = 14'h3F9C;
        measure(16'd0, 2, -1, 60, de);
        check_eq("ofs_done_edge", de, 32'd19);
        check_eq("ofs_out", adc_out, 32'h0000_FFF8);
        adc_en = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spgd_adc_acquire.md
# spgd_adc_acquire

Measurement front end for the SPGD loop: the responder side of the `ADC_EN` / `ADC_DONE` handshake that the SPGD control FSM initiates for each J+ and J− measurement.
- On request, waits a programmable settling time after the DAC update, averages 2^LOG2_AVG raw ADC samples, and converts the mean to the loop's signed fixed-point format.
- Presents the result on `ADC_OUT`, which feeds the J_P/J_M capture registers, and asserts `ADC_DONE`.

## Interface
Parameters:
- FP_WIDTH, 32, width of fixed-point result, signed Q(INT_WIDTH).(FP_WIDTH−INT_WIDTH)
- INT_WIDTH, 16, integer bits of result
- RAW_WIDTH, 14, raw ADC sample width, signed two's complement
- LOG2_AVG, 4, log2 of samples averaged (N = 16)
- SETTLE_W, 16, width of settle counter

Ports (one clock; reset is asynchronous and active-low):
- ADC_CLK  in  1  system clock, all logic on rising edge
- REG_RST_N  in  1  asynchronous active-low reset
- ADC_EN  in  1  measurement request from SPGD FSM, level
- ADC_RAW  in  RAW_WIDTH  raw signed ADC sample
- ADC_RAW_VALID  in  1  ADC_RAW valid this cycle
- SETTLE_CYC  in  SETTLE_W  settle delay in clocks, sampled at request start
- ADC_OFFSET  in  RAW_WIDTH  signed offset (only with ADC_OFFSET_EN)
- ADC_OUT  out  FP_WIDTH  averaged, scaled measurement
- ADC_DONE  out  1  result valid, four-phase acknowledge
- BUSY  out  1  high in SETTLE, ACCUM, SCALE

## Operation
- States: IDLE, SETTLE, ACCUM, SCALE, DONE.
- IDLE: if ADC_EN=1, load settle counter with SETTLE_CYC, clear accumulator and sample count, go to SETTLE.
- SETTLE: if counter==0 go to ACCUM, else decrement. ADC_RAW is ignored.
- ACCUM: on each cycle with ADC_RAW_VALID=1, add sign-extended sample to accumulator (RAW_WIDTH+LOG2_AVG bits, cannot overflow). After the N-th valid sample go to SCALE.
- SCALE: avg = acc >>> LOG2_AVG (arithmetic, floor). ADC_OUT ← sext(avg) <<< (FP_WIDTH−INT_WIDTH−(RAW_WIDTH−1)), so raw full scale ±2^(RAW_WIDTH−1) maps to ±1.0. Go to DONE.
- Elaboration-time error if FP_WIDTH−INT_WIDTH < RAW_WIDTH−1.
- DONE: ADC_DONE=1. Hold until ADC_EN=0, then go to IDLE with ADC_DONE=0.
- Abort: ADC_EN=0 in SETTLE, ACCUM or SCALE returns to IDLE next cycle. ADC_OUT is unchanged and ADC_DONE is not asserted.
- ADC_OUT holds its value between measurements; it changes only on the SCALE→DONE edge.
- Reset (any state, asynchronous): state IDLE, ADC_OUT=0, ADC_DONE=0, BUSY=0, counters and accumulator 0.

## Timing
- ADC_EN is sampled at edge 0. With ADC_RAW_VALID continuously high, ADC_DONE rises at edge SETTLE_CYC+N+3.
- Gaps in ADC_RAW_VALID extend ACCUM one cycle per gap.
- ADC_DONE falls on the first edge after ADC_EN is sampled low. A new request is accepted no earlier than the following edge.
- SETTLE_CYC changes after the request starts have no effect on the current measurement.
- ADC_EN held high across DONE does not start a second measurement. It must drop first.

## Configuration
- ADC_OFFSET_EN defined:
  - ADC_OFFSET port exists.
  - Each valid sample becomes ADC_RAW−ADC_OFFSET, computed at RAW_WIDTH+1 bits and saturated to [−2^(RAW_WIDTH−1), 2^(RAW_WIDTH−1)−1] before accumulation.
  - ADC_OFFSET is sampled per sample.
- ADC_OFFSET_EN undefined: port absent; raw samples are accumulated directly.

## Structure
- Shared package spgd_adc_pkg holds:
  - state enumeration (IDLE, SETTLE, ACCUM, SCALE, DONE)
  - FRAC_SHIFT constant function of FP_WIDTH, INT_WIDTH, RAW_WIDTH
  - saturation helper for the offset path
- One sub-module, spgd_adc_accum:
  - inputs: clear, enable, sample
  - outputs: accumulator and a count-reached flag
- The top level holds the FSM, settle counter and output register.

## Test plan
- Reset mid-ACCUM with REG_RST_N low for 1 cycle → ADC_OUT=0, ADC_DONE=0, BUSY=0 immediately; the next request behaves normally.
- SETTLE_CYC=0, constant ADC_RAW=4096, valid always high, ADC_EN held high → ADC_DONE rises at edge 19, ADC_OUT=0x0000_8000 (0.5). ADC_EN low → ADC_DONE low next edge.
- SETTLE_CYC=5, alternating ADC_RAW −8192 / 8191, ADC_RAW_VALID high every other cycle → 16 valid samples accumulated, avg=floor(−0.5)=−1, ADC_OUT=0xFFFF_FFF8, ADC_DONE at edge 40.
- ADC_EN dropped during SETTLE and again during ACCUM → returns to IDLE, ADC_DONE never asserted, ADC_OUT retains previous value.
- ADC_EN kept high for 50 cycles after ADC_DONE → exactly one measurement, BUSY stays 0 in DONE.
- With ADC_OFFSET_EN, ADC_OFFSET=−100, ADC_RAW=8150 → each sample saturates to 8191, ADC_OUT=0x0000_FFF8.
